// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access widths, FSM states and the
// alignment check used by both the controller and the load extender.
package lsu_pkg;

    localparam logic [1:0] MEM_B   = 2'd0;
    localparam logic [1:0] MEM_H   = 2'd1;
    localparam logic [1:0] MEM_W   = 2'd2;
    localparam logic [1:0] MEM_ILL = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_DONE = 2'd2,
        RESP    = 2'd3
    } lsu_state_e;

    // True when the width is illegal or the byte offset breaks natural alignment.
    function automatic logic req_bad(input logic [1:0] width, input logic [1:0] off);
        logic bad;
        case (width)
            MEM_B:   bad = 1'b0;
            MEM_H:   bad = off[0];
            MEM_W:   bad = (off != 2'd0);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Combinational load-data extender: memory data arrives zero-extended and
// low-aligned; this applies sign/zero extension for byte and half loads.
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [1:0]  width_i,
    input  logic        unsigned_i,
    input  logic [1:0]  offset_i,
    output logic [31:0] result_o
);

    // Extend by width; an access that could never have been issued yields zero.
    always_comb begin
        result_o = 32'd0;
        if (req_bad(width_i, offset_i)) begin
            result_o = 32'd0;
        end else begin
            case (width_i)
                MEM_B:   result_o = {{24{~unsigned_i & data_i[7]}}, data_i[7:0]};
                MEM_H:   result_o = {{16{~unsigned_i & data_i[15]}}, data_i[15:0]};
                MEM_W:   result_o = data_i;
                default: result_o = 32'd0;
            endcase
        end
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one request at a time, issues a single-cycle memory
// strobe, and returns a one-cycle response with extended load data or an error.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_width,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_read_valid,
    output logic        mem_write_valid,
    output logic [31:0] mem_write_data,
    output logic [1:0]  mem_width,
    input  logic [31:0] mem_read_data,
    input  logic        mem_ready
);

    localparam int unsigned     CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       width_q;
    logic             uns_q;
    logic [1:0]       off_q;
    logic             req_ready_q;
    logic             resp_valid_q;
    logic             resp_err_q;
    logic [31:0]      resp_rdata_q;
    logic [31:0]      mem_addr_q;
    logic             mem_rd_q;
    logic             mem_wr_q;
    logic [31:0]      mem_wdata_q;
    logic [1:0]       mem_width_q;
    logic [31:0]      ext_s;

    lsu_extend u_extend (
        .data_i     (mem_read_data),
        .width_i    (width_q),
        .unsigned_i (uns_q),
        .offset_i   (off_q),
        .result_o   (ext_s)
    );

    // Controller FSM; strobes and the response are single-cycle pulses cleared by default.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            width_q      <= 2'd0;
            uns_q        <= 1'b0;
            off_q        <= 2'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
            mem_addr_q   <= 32'd0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_wdata_q  <= 32'd0;
            mem_width_q  <= 2'd0;
        end else begin
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        width_q     <= req_width;
                        uns_q       <= req_unsigned;
                        off_q       <= req_addr[1:0];
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
                        if (req_bad(req_width, req_addr[1:0])) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else if (req_store) begin
                            state_q     <= WR_DONE;
                            mem_wr_q    <= 1'b1;
                            mem_addr_q  <= req_addr;
                            mem_width_q <= req_width;
                            mem_wdata_q <= req_wdata;
                        end else begin
                            state_q     <= RD_WAIT;
                            mem_rd_q    <= 1'b1;
                            mem_addr_q  <= req_addr;
                            mem_width_q <= req_width;
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    // A ready on the last counted cycle still wins over the timeout.
                    if (mem_ready) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= ext_s;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                WR_DONE: begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                end
                RESP: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready       = req_ready_q;
    assign resp_valid      = resp_valid_q;
    assign resp_err        = resp_err_q;
    assign resp_rdata      = resp_rdata_q;
    assign mem_addr        = mem_addr_q;
    assign mem_read_valid  = mem_rd_q;
    assign mem_write_valid = mem_wr_q;
    assign mem_write_data  = mem_wdata_q;
    assign mem_width       = mem_width_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: a vector table of single requests driven against
// a scripted memory responder, plus reset-abort and held-valid store sequences.
module tb_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_width;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic        mem_read_valid;
    logic        mem_write_valid;
    logic [31:0] mem_write_data;
    logic [1:0]  mem_width;
    logic [31:0] mem_read_data;
    logic        mem_ready;

    lsu #(.TIMEOUT(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_store       (req_store),
        .req_width       (req_width),
        .req_unsigned    (req_unsigned),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_err        (resp_err),
        .resp_rdata      (resp_rdata),
        .mem_addr        (mem_addr),
        .mem_read_valid  (mem_read_valid),
        .mem_write_valid (mem_write_valid),
        .mem_write_data  (mem_write_data),
        .mem_width       (mem_width),
        .mem_read_data   (mem_read_data),
        .mem_ready       (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        store;
        logic [1:0]  width;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        int          delay;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_addr = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic sb_pop(input string nm);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: unexpected resp_valid, got 1 expected 0", nm);
        end else begin
            e = sb_q.pop_front();
            chk({nm, " resp_err"}, 32'(resp_err), 32'(e.err));
            chk({nm, " resp_rdata"}, resp_rdata, e.rdata);
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        bit   seen;
        logic legal;
        legal = !(v.exp_err && v.exp_lat == 1);
        chk({nm, " req_ready before"}, 32'(req_ready), 32'd1);
        req_valid     = 1'b1;
        req_store     = v.store;
        req_width     = v.width;
        req_unsigned  = v.uns;
        req_addr      = v.addr;
        req_wdata     = v.wdata;
        mem_read_data = v.mrdata;
        sb_q.push_back('{v.exp_err, v.exp_rdata});
        seen = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            chk({nm, " mem_read_valid"}, 32'(mem_read_valid), 32'(c == 1 && legal && !v.store));
            chk({nm, " mem_write_valid"}, 32'(mem_write_valid), 32'(c == 1 && legal && v.store));
            if (c == 1 && legal) begin
                chk({nm, " mem_addr"}, mem_addr, v.addr);
                chk({nm, " mem_width"}, 32'(mem_width), 32'(v.width));
                if (v.store) begin
                    chk({nm, " mem_write_data"}, mem_write_data, v.wdata);
                end
                last_addr = v.addr;
            end else if (c == 1) begin
                chk({nm, " mem_addr held"}, mem_addr, last_addr);
            end
            if (resp_valid) begin
                seen = 1'b1;
                chk({nm, " latency"}, 32'(c), 32'(v.exp_lat));
                sb_pop(nm);
            end
            mem_ready = (v.delay >= 0 && c == 1 + v.delay);
        end
        mem_ready = 1'b0;
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no response, got none expected cycle %0d", nm, v.exp_lat);
            void'(sb_q.pop_front());
        end
        @(negedge clk);
        chk({nm, " resp_valid single pulse"}, 32'(resp_valid), 32'd0);
        chk({nm, " req_ready after"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        bit [7:0] wr_mask;
        bit [7:0] resp_mask;

        rst           = 1'b1;
        req_valid     = 1'b0;
        req_store     = 1'b0;
        req_width     = 2'd0;
        req_unsigned  = 1'b0;
        req_addr      = 32'd0;
        req_wdata     = 32'd0;
        mem_read_data = 32'd0;
        mem_ready     = 1'b0;

        //           store  width  uns   addr        wdata          mrdata         dly  err   rdata          lat
        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h10, 32'h8000_80F0, 32'h0,         -1, 1'b0, 32'h0,         2});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h10, 32'h0,         32'h0000_00F0,  1, 1'b0, 32'hFFFF_FFF0, 3});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h12, 32'h0,         32'h0000_8000,  1, 1'b0, 32'h0000_8000, 3});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h12, 32'h0,         32'h0000_8000,  1, 1'b0, 32'hFFFF_8000, 3});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h13, 32'h0,         32'h1234_5678, -1, 1'b1, 32'h0,         1});
        vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h11, 32'h0,         32'h0000_00F0,  1, 1'b0, 32'h0000_00F0, 3});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h03, 32'h0,         32'h0000_007F,  1, 1'b0, 32'h0000_007F, 3});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h20, 32'h0,         32'h8765_4321,  0, 1'b0, 32'h8765_4321, 2});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h11, 32'h0,         32'h0000_FFFF, -1, 1'b1, 32'h0,         1});
        vecs.push_back('{1'b0, 2'd3, 1'b0, 32'h00, 32'h0,         32'h0000_FFFF, -1, 1'b1, 32'h0,         1});
        vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h13, 32'hCAFE_F00D, 32'h0,         -1, 1'b1, 32'h0,         1});
        vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h13, 32'hDEAD_BEEF, 32'h0,         -1, 1'b0, 32'h0,         2});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h02, 32'h0,         32'h0000_7FFF,  3, 1'b0, 32'h0000_7FFF, 5});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h40, 32'h0,         32'hFFFF_FFFF, -1, 1'b1, 32'h0,        17});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h06, 32'h0,         32'h0000_FFFF,  1, 1'b0, 32'hFFFF_FFFF, 3});

        // Reset state, observed while reset is still applied.
        repeat (2) @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset resp_err", 32'(resp_err), 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'd0);
        chk("reset mem_read_valid", 32'(mem_read_valid), 32'd0);
        chk("reset mem_write_valid", 32'(mem_write_valid), 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while waiting for a read, then a late mem_ready must be ignored.
        req_valid = 1'b1;
        req_store = 1'b0;
        req_width = 2'd2;
        req_addr  = 32'h60;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort read strobe", 32'(mem_read_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort resp_valid", 32'(resp_valid), 32'd0);
        chk("abort req_ready", 32'(req_ready), 32'd1);
        chk("abort mem_addr", mem_addr, 32'd0);
        rst           = 1'b0;
        mem_ready     = 1'b1;
        mem_read_data = 32'h0000_1234;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("late ready resp_valid", 32'(resp_valid), 32'd0);
        chk("late ready req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        chk("late ready resp_valid 2", 32'(resp_valid), 32'd0);
        last_addr = 32'd0;

        // Store with req_valid held: accepted at edges 0 and 3.
        wr_mask   = 8'd0;
        resp_mask = 8'd0;
        req_valid = 1'b1;
        req_store = 1'b1;
        req_width = 2'd2;
        req_addr  = 32'h50;
        req_wdata = 32'hA5A5_5A5A;
        sb_q.push_back('{1'b0, 32'h0});
        sb_q.push_back('{1'b0, 32'h0});
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 4) begin
                req_valid = 1'b0;
            end
            chk("held strobe exclusive", 32'(mem_read_valid && mem_write_valid), 32'd0);
            if (mem_write_valid) begin
                wr_mask[c] = 1'b1;
            end
            if (resp_valid) begin
                resp_mask[c] = 1'b1;
                sb_pop("held store");
            end
        end
        chk("held store write pulses", 32'(wr_mask), 32'h12);
        chk("held store resp cycles", 32'(resp_mask), 32'h24);
        chk("held store scoreboard drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
